multiplier_seq: RTL and testbench

- Sequential unsigned shift-add multiplier. It is the inverse arithmetic companion to the team's repeated-subtraction divider.
- Accepts two WIDTH-bit operands on a start pulse and iterates one multiplier bit per clock.
- Returns a 2*WIDTH-bit product with a one-cycle done pulse.
- Used by datapath control that needs multiply without a combinational array.

---
 rtl/multiplier_seq.sv | 107 ++++++++++
 tb/tb_multiplier_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_seq.sv
`default_nettype none
// ============================================================================
// multiplier_seq : sequential unsigned shift-add multiplier, one multiplier
//                  bit per clock, 2*WIDTH-bit product with a one-cycle done.
// Optional macro MULT_EARLY_EXIT_EN ends the iteration once the remaining
// multiplier bits are all zero.
// Revision: 1.0
// ============================================================================
module multiplier_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    localparam int c_pw = 2 * WIDTH;
    localparam int c_cw = $clog2(WIDTH) + 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [c_pw-1:0]   acc_q;
    logic [c_pw-1:0]   mcand_q;
    logic [c_pw-1:0]   product_q;
    logic [WIDTH-1:0]  mplr_q;
    logic [c_cw-1:0]   cnt_q;
    logic              busy_q;
    logic              done_q;

    logic [c_pw-1:0]   acc_d;
    logic              last_d;

    always_comb begin
        acc_d = mplr_q[0] ? (acc_q + mcand_q) : acc_q;
`ifdef MULT_EARLY_EXIT_EN
        // Next shifted multiplier is zero: no further partial products to add.
        last_d = (cnt_q == c_last) || (mplr_q[WIDTH-1:1] == '0);
`else
        last_d = (cnt_q == c_last);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplr_q    <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        acc_q   <= '0;
                        mcand_q <= {{WIDTH{1'b0}}, multiplicand};
                        mplr_q  <= multiplier;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    acc_q   <= acc_d;
                    mcand_q <= mcand_q << 1;
                    mplr_q  <= mplr_q >> 1;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last_d) begin
                        product_q <= acc_d;
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign product = product_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_multiplier_seq.sv
`default_nettype none
// ============================================================================
// tb_multiplier_seq : directed and exhaustive checks of multiplier_seq with a
//                     product/latency scoreboard. Honours MULT_EARLY_EXIT_EN.
// Revision: 1.0
// ============================================================================
module tb_multiplier_seq;

    localparam int W  = 4;
    localparam int PW = 2 * W;

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  multiplicand;
    logic [W-1:0]  multiplier;
    logic [PW-1:0] product;
    logic          busy;
    logic          done;

    multiplier_seq #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [PW-1:0] prod;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   sweep_on = 1'b0;
    int   last_done = -1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input logic [W-1:0] b);
`ifdef MULT_EARLY_EXIT_EN
        int p = 0;
        for (int i = 0; i < W; i++) if (b[i]) p = i;
        return p + 1;
`else
        return W;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push expectation for an operation accepted at the next edge.
    task automatic push_op(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.prod = PW'(a) * PW'(b);
        e.cyc  = cyc + 1 + exp_lat(b);
        sb.push_back(e);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int lat;
        lat = exp_lat(b);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        push_op(a, b);
        tick();
        start = 1'b0;
        for (int k = 0; k <= lat; k++) begin
            check("busy_hi", 64'(busy), 64'd1);
            tick();
        end
        check("busy_lo", 64'(busy), 64'd0);
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                check("extra_done", 64'(done), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("product", 64'(product), 64'(e.prod));
                check("done_cycle", 64'(cyc), 64'(e.cyc));
                check("busy_in_done", 64'(busy), 64'd1);
`ifndef MULT_EARLY_EXIT_EN
                if (sweep_on && last_done >= 0)
                    check("spacing", 64'(cyc - last_done), 64'(W + 2));
`endif
                last_done = cyc;
            end
        end
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        multiplicand = '0;
        multiplier = '0;
        tick();
        tick();
        check("rst_product", 64'(product), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        tick();

        run_op(4'd13, 4'd11);
        check("prod_13x11", 64'(product), 64'h8F);
        run_op(4'd15, 4'd15);
        check("prod_15x15", 64'(product), 64'hE1);
        run_op(4'd0, 4'd9);
        run_op(4'd9, 4'd0);
        run_op(4'd9, 4'd1);

        // Start requests during an operation must be ignored.
        multiplicand = 4'd6;
        multiplier   = 4'd7;
        start        = 1'b1;
        push_op(4'd6, 4'd7);
        tick();
        for (int t = 0; t < 20; t++) begin
            start = 1'b1;
            multiplicand = 4'd3;
            multiplier   = 4'd3;
            tick();
            if (!busy) break;
        end
        start = 1'b0;
        check("busy_after_6x7", 64'(busy), 64'd0);
        repeat (W + 3) tick();
        check("prod_42_held", 64'(product), 64'd42);
        check("busy_idle_6x7", 64'(busy), 64'd0);

        // Reset on the second BUSY edge aborts with no done.
        multiplicand = 4'd12;
        multiplier   = 4'd5;
        start        = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("abort_product", 64'(product), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        rst = 1'b0;
        repeat (8) tick();
        check("abort_product_hold", 64'(product), 64'd0);
        run_op(4'd2, 4'd3);
        check("prod_2x3", 64'(product), 64'd6);

        run_op(4'd5, 4'd5);
        for (int t = 0; t < 10; t++) begin
            check("idle_product", 64'(product), 64'd25);
            check("idle_done", 64'(done), 64'd0);
            tick();
        end

        // Exhaustive sweep with start held high.
        sweep_on  = 1'b1;
        last_done = -1;
        start     = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                multiplicand = W'(a);
                multiplier   = W'(b);
                push_op(W'(a), W'(b));
                tick();
                for (int t = 0; t < 40 && busy; t++) tick();
                check("sweep_idle", 64'(busy), 64'd0);
            end
        end
        start = 1'b0;
        repeat (W + 4) tick();
        sweep_on = 1'b0;
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
